mc_dp: RTL

- Multi-cycle MIPS-subset datapath with an integrated control FSM; the parametrised successor to the single-cycle datapath.
- One shared memory port carries both instruction fetch and data access, with a req/ready handshake, so memory may stall for any number of cycles.
- Datapath width and register-file depth are generic.
- Trace ports expose register writes and instruction retirement to the bench.

---
 rtl/mc_dp.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_dp.sv
// mc_dp: multi-cycle MIPS-subset datapath with integrated control FSM.
//
// One shared memory port carries both instruction fetch and data access.
// Every memory state holds its request until MemReady, so the memory may
// stall for any number of cycles.
//
// Ports:
//   Clk, Reset            clock (rising edge), asynchronous active-high reset
//   MemReq/MemWe          memory request valid / write request
//   MemAddr/MemWData      byte address / store data
//   MemReady/MemRData     memory accept (read data valid in the same cycle)
//   PC, State             current instruction address, FSM state (debug)
//   RegWe/RegAddr/RegWData  register-write trace, one cycle after the write
//   Retire                one-cycle pulse after an instruction completes
//
// Supported instructions:
//   addu subu jr addiu ori lui lw sw beq j jal. Anything else executes as a nop.
module mc_dp #(
  parameter int          WIDTH    = 32,
  parameter int          NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic             MemReq,
  output logic             MemWe,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] MemWData,
  input  logic             MemReady,
  input  logic [WIDTH-1:0] MemRData,
  output logic [WIDTH-1:0] PC,
  output logic [2:0]       State,
  output logic             RegWe,
  output logic [4:0]       RegAddr,
  output logic [WIDTH-1:0] RegWData,
  output logic             Retire
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [4:0] RA_IDX = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic             reg_we_q, reg_we_d;
  logic [4:0]       reg_addr_q, reg_addr_d;
  logic [WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic             retire_q, retire_d;

  logic [WIDTH-1:0] regs_q [NREG];

  // Register-file write port, driven from the FSM below
  logic             rf_we;
  logic [AW-1:0]    rf_idx;
  logic [WIDTH-1:0] rf_wdata;

  // Memory-port values before the reset gate
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs_f, rt_f, rd_f;
  logic [15:0] imm16;
  logic [AW-1:0] rs_idx, rt_idx;
  logic [WIDTH-1:0] rs_val, rt_val;
  logic [WIDTH-1:0] imm_sext, imm_zext;
  logic [WIDTH-1:0] pc_plus4, jump_target;
  logic is_addu, is_subu, is_jr, is_addiu, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, is_alu;

  assign op     = ir_q[31:26];
  assign rs_f   = ir_q[25:21];
  assign rt_f   = ir_q[20:16];
  assign rd_f   = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign imm16  = ir_q[15:0];
  assign rs_idx = rs_f[AW-1:0];
  assign rt_idx = rt_f[AW-1:0];

  // Index 0 (after truncation to AW bits) is the hard-wired zero register
  assign rs_val = (rs_idx == '0) ? '0 : regs_q[rs_idx];
  assign rt_val = (rt_idx == '0) ? '0 : regs_q[rt_idx];

  assign imm_sext    = {{(WIDTH-16){imm16[15]}}, imm16};
  assign imm_zext    = {{(WIDTH-16){1'b0}}, imm16};
  assign pc_plus4    = pc_q + WIDTH'(4);
  assign jump_target = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};

  assign is_addu  = (op == OP_RTYPE) && (funct == FN_ADDU);
  assign is_subu  = (op == OP_RTYPE) && (funct == FN_SUBU);
  assign is_jr    = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_addiu = (op == OP_ADDIU);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_alu   = is_addu | is_subu | is_addiu | is_ori | is_lui;

  // Next-state, datapath register updates and memory-port drive
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    alu_d       = alu_q;
    mdr_d       = mdr_q;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    retire_d    = 1'b0;
    rf_we       = 1'b0;
    rf_idx      = '0;
    rf_wdata    = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (MemReady) begin
          ir_d    = MemRData[31:0];
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        a_d = rs_val;
        b_d = rt_val;
        if (is_ori)
          imm_d = imm_zext;
        else if (is_lui)
          imm_d = imm_sext << 16;
        else
          imm_d = imm_sext;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (is_alu) begin
          if (is_addu)
            alu_d = a_q + b_q;
          else if (is_subu)
            alu_d = a_q - b_q;
          else if (is_addiu)
            alu_d = a_q + imm_q;
          else if (is_ori)
            alu_d = a_q | imm_q;
          else
            alu_d = imm_q;
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          alu_d   = a_q + imm_q;
          state_d = S_MEM;
        end else begin
          // Control-flow and unrecognised instructions finish here
          retire_d = 1'b1;
          state_d  = S_FETCH;
          if (is_beq)
            pc_d = (a_q == b_q) ? (pc_plus4 + (imm_q << 2)) : pc_plus4;
          else if (is_j)
            pc_d = jump_target;
          else if (is_jal) begin
            pc_d        = jump_target;
            rf_we       = 1'b1;
            rf_idx      = RA_IDX[AW-1:0];
            rf_wdata    = pc_plus4;
            reg_we_d    = 1'b1;
            reg_addr_d  = RA_IDX;
            reg_wdata_d = pc_plus4;
          end else if (is_jr)
            pc_d = a_q;
          else
            pc_d = pc_plus4;
        end
      end

      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = alu_q;
        if (is_sw) begin
          mem_we    = 1'b1;
          mem_wdata = b_q;
        end
        if (MemReady) begin
          if (is_sw) begin
            pc_d     = pc_plus4;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = MemRData;
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we       = 1'b1;
        rf_idx      = (op == OP_RTYPE) ? rd_f[AW-1:0] : rt_f[AW-1:0];
        rf_wdata    = is_lw ? mdr_q : alu_q;
        reg_we_d    = 1'b1;
        reg_addr_d  = (op == OP_RTYPE) ? rd_f : rt_f;
        reg_wdata_d = rf_wdata;
        pc_d        = pc_plus4;
        retire_d    = 1'b1;
        state_d     = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_FETCH;
      pc_q        <= WIDTH'(RESET_PC);
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      alu_q       <= '0;
      mdr_q       <= '0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      retire_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      alu_q       <= alu_d;
      mdr_q       <= mdr_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      retire_q    <= retire_d;
    end
  end

  // Register file; writes to the zero register are dropped
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else if (rf_we && (rf_idx != '0)) begin
      regs_q[rf_idx] <= rf_wdata;
    end
  end

  // Reset forces the state to FETCH, which would otherwise raise a request;
  // gating here drops the port immediately, even mid-transaction.
  assign MemReq   = mem_req & ~Reset;
  assign MemWe    = mem_we & ~Reset;
  assign MemAddr  = Reset ? '0 : mem_addr;
  assign MemWData = Reset ? '0 : mem_wdata;

  assign PC       = pc_q;
  assign State    = state_q;
  assign RegWe    = reg_we_q;
  assign RegAddr  = reg_addr_q;
  assign RegWData = reg_wdata_q;
  assign Retire   = retire_q;

endmodule
